// File: rtl/lcd_timing_gen.sv
// LCD/LTM panel raster timing generator with frame-store prefetch addressing and a
// latency-compensated pixel formatter (gray, RGB888, solid mask, colour bars).
module lcd_timing_gen #(
    parameter int H_TOTAL     = 1056,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 216,
    parameter int H_ACT_W     = 800,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_H     = 480,
    parameter int FETCH_LAT   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_continuous,
    input  logic [1:0]  i_mode,
    input  logic [2:0]  i_rgb_mask,
    input  logic        i_vflip,
    input  logic [23:0] i_data,
    output logic [9:0]  o_addr_x,
    output logic [8:0]  o_addr_y,
    output logic        o_addr_valid,
    output logic        o_HD,
    output logic        o_VD,
    output logic        o_DEN,
    output logic [7:0]  o_R,
    output logic [7:0]  o_G,
    output logic [7:0]  o_B,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_frame_cnt
);

    localparam int XW    = $clog2(H_TOTAL);
    localparam int YW    = $clog2(V_TOTAL);
    localparam int L     = FETCH_LAT + 1;
    localparam int BAR_W = H_ACT_W / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_mode;
    logic [2:0]    r_mask;
    logic          r_vflip;
    logic [15:0]   r_frame_cnt;

    logic          w_busy;
    logic          w_x_end;
    logic          w_y_end;
    logic          w_eof;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_active;
    logic [XW-1:0] w_xoff;
    logic [YW-1:0] w_yoff;
    logic [YW-1:0] w_yrow;

    assign w_busy   = (r_state == S_RUN);
    assign w_x_end  = (r_x == XW'(H_TOTAL - 1));
    assign w_y_end  = (r_y == YW'(V_TOTAL - 1));
    assign w_eof    = w_busy & w_x_end & w_y_end;
    assign w_h_act  = (32'(r_x) >= H_ACT_START) && (32'(r_x) < H_ACT_START + H_ACT_W);
    assign w_v_act  = (32'(r_y) >= V_ACT_START) && (32'(r_y) < V_ACT_START + V_ACT_H);
    assign w_active = w_busy & w_h_act & w_v_act;

    assign w_xoff = r_x - XW'(H_ACT_START);
    assign w_yoff = r_y - YW'(V_ACT_START);
    assign w_yrow = r_vflip ? (YW'(V_ACT_H - 1) - w_yoff) : w_yoff;

    assign o_addr_x     = w_active ? 10'(w_xoff) : '0;
    assign o_addr_y     = w_active ? 9'(w_yrow) : '0;
    assign o_addr_valid = w_active;
    assign o_busy       = w_busy;
    assign o_frame_done = w_eof;
    assign o_frame_cnt  = r_frame_cnt;

    // Raster scan; a start (or a continuous wrap) always restarts at (0,0) and relatches modes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= '0;
            r_mask      <= '0;
            r_vflip     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_mode  <= i_mode;
                        r_mask  <= i_rgb_mask;
                        r_vflip <= i_vflip;
                    end
                end
                S_RUN: begin
                    if (w_eof) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                    if (i_start || (w_eof && i_continuous)) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_mode  <= i_mode;
                        r_mask  <= i_rgb_mask;
                        r_vflip <= i_vflip;
                    end else if (w_eof) begin
                        r_state <= S_IDLE;
                        r_x     <= '0;
                        r_y     <= '0;
                    end else if (w_x_end) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bar index of the current pixel: counts BAR_W-pixel runs along the active line.
    logic [BW-1:0] r_bpix;
    logic [2:0]    r_bar;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bpix <= '0;
            r_bar  <= '0;
        end else if (!w_active || i_start) begin
            r_bpix <= '0;
            r_bar  <= '0;
        end else if (r_bpix == BW'(BAR_W - 1)) begin
            r_bpix <= '0;
            r_bar  <= r_bar + 3'd1;
        end else begin
            r_bpix <= r_bpix + 1'b1;
        end
    end

    logic [L-1:0] r_hd_p;
    logic [L-1:0] r_vd_p;
    logic [L-1:0] r_den_p;
    logic [2:0]   r_bar_p [FETCH_LAT];
    logic         w_hd_raw;
    logic         w_vd_raw;
    logic         w_den_d;
    logic [2:0]   w_bar_d;

    assign w_hd_raw = !(w_busy && (r_x == '0));
    assign w_vd_raw = !(w_busy && (r_y == '0));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hd_p  <= '1;
            r_vd_p  <= '1;
            r_den_p <= '0;
            for (int i = 0; i < FETCH_LAT; i++) r_bar_p[i] <= '0;
        end else begin
            r_hd_p     <= {r_hd_p[L-2:0], w_hd_raw};
            r_vd_p     <= {r_vd_p[L-2:0], w_vd_raw};
            r_den_p    <= {r_den_p[L-2:0], w_active};
            r_bar_p[0] <= r_bar;
            for (int i = 1; i < FETCH_LAT; i++) r_bar_p[i] <= r_bar_p[i-1];
        end
    end

    // Tap at FETCH_LAT lines up with i_data for the same pixel; the register adds the last stage.
    assign w_den_d = r_den_p[FETCH_LAT-1];
    assign w_bar_d = r_bar_p[FETCH_LAT-1];

    assign o_HD  = r_hd_p[L-1];
    assign o_VD  = r_vd_p[L-1];
    assign o_DEN = r_den_p[L-1];

    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (!w_den_d) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else begin
            case (r_mode)
                2'b00: begin
                    r_r <= i_data[7:0];
                    r_g <= i_data[7:0];
                    r_b <= i_data[7:0];
                end
                2'b01: begin
                    r_r <= i_data[23:16];
                    r_g <= i_data[15:8];
                    r_b <= i_data[7:0];
                end
                2'b10: begin
                    r_r <= {8{r_mask[2]}};
                    r_g <= {8{r_mask[1]}};
                    r_b <= {8{r_mask[0]}};
                end
                default: begin
                    r_r <= {8{w_bar_d[2]}};
                    r_g <= {8{w_bar_d[1]}};
                    r_b <= {8{w_bar_d[0]}};
                end
            endcase
        end
    end

    assign o_R = r_r;
    assign o_G = r_g;
    assign o_B = r_b;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen on a shrunken raster; expected pixels are queued
// at frame start and popped by a monitor whenever DEN is high.
module tb_lcd_timing_gen;

    localparam int H_T = 24, V_T = 10, HS = 5, HW = 16, VS = 2, VH = 5, FL = 2;
    localparam int L = FL + 1;
    localparam int FRAME = H_T * V_T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  mask = 3'd0;
    logic        vflip = 1'b0;
    logic [23:0] data;
    logic [9:0]  o_addr_x;
    logic [8:0]  o_addr_y;
    logic        o_addr_valid, o_HD, o_VD, o_DEN, o_busy, o_frame_done;
    logic [7:0]  o_R, o_G, o_B;
    logic [15:0] o_frame_cnt;

    int n_chk = 0, n_pass = 0;
    int n_hd = 0, n_vd = 0, n_den = 0, n_done = 0;
    logic [23:0] exp_q[$];

    lcd_timing_gen #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACT_START(HS), .H_ACT_W(HW),
        .V_ACT_START(VS), .V_ACT_H(VH), .FETCH_LAT(FL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_continuous(cont),
        .i_mode(mode), .i_rgb_mask(mask), .i_vflip(vflip), .i_data(data),
        .o_addr_x(o_addr_x), .o_addr_y(o_addr_y), .o_addr_valid(o_addr_valid),
        .o_HD(o_HD), .o_VD(o_VD), .o_DEN(o_DEN),
        .o_R(o_R), .o_G(o_G), .o_B(o_B),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_word(int ax, int ay);
        return {8'(ax), 8'(ay), 8'(ax * 3 + ay)};
    endfunction

    function automatic logic [23:0] pix_of(int m, logic [2:0] mk, int ax, int ay);
        logic [23:0] w;
        logic [7:0]  g;
        logic [2:0]  b;
        w = mem_word(ax, ay);
        g = w[7:0];
        b = 3'(ax / (HW / 8));
        case (m)
            0:       return {g, g, g};
            1:       return w;
            2:       return {{8{mk[2]}}, {8{mk[1]}}, {8{mk[0]}}};
            default: return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        endcase
    endfunction

    // Frame store model: returns the word for the presented address FL cycles later.
    logic [23:0] ram_p [FL];
    always @(posedge clk) begin
        ram_p[0] <= mem_word(int'(o_addr_x), int'(o_addr_y));
        for (int i = 1; i < FL; i++) ram_p[i] <= ram_p[i-1];
    end
    assign data = ram_p[FL-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input int m, input logic [2:0] mk, input bit vf, input int lim);
        int n;
        n = 0;
        for (int r = 0; r < VH; r++)
            for (int c = 0; c < HW; c++)
                if (lim < 0 || n < lim) begin
                    exp_q.push_back(pix_of(m, mk, c, vf ? (VH - 1 - r) : r));
                    n++;
                end
    endtask

    task automatic check_idle(input string t, input int cnt);
        chk({t, "_HD"}, o_HD, 1);
        chk({t, "_VD"}, o_VD, 1);
        chk({t, "_DEN"}, o_DEN, 0);
        chk({t, "_RGB"}, {o_R, o_G, o_B}, 0);
        chk({t, "_addr"}, {o_addr_valid, o_addr_y, o_addr_x}, 0);
        chk({t, "_busy"}, o_busy, 0);
        chk({t, "_done"}, o_frame_done, 0);
        chk({t, "_cnt"}, o_frame_cnt, cnt);
    endtask

    task automatic wait_done(input int lim, input string tag, output int n);
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (o_frame_done) begin n = i; return; end
        end
        n = -1;
        n_chk++;
        $display("FAIL %s: frame_done not seen within %0d cycles", tag, lim);
    endtask

    task automatic wait_addr(input int lim, input string tag, input bit any, input int ax, input int ay);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (o_addr_valid && (any || (int'(o_addr_x) == ax && int'(o_addr_y) == ay))) return;
        end
        n_chk++;
        $display("FAIL %s: address not seen within %0d cycles", tag, lim);
    endtask

    // Monitor: counts sync activity and checks every DEN pixel against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (!o_HD) n_hd++;
            if (!o_VD) n_vd++;
            if (o_frame_done) n_done++;
            if (o_DEN) begin
                n_den++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pixel_extra: got %0h expected none", {o_R, o_G, o_B});
                end else begin
                    chk("pixel", {o_R, o_G, o_B}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int h0, v0, d0, k0, n, lat;
        logic [15:0] c0;

        repeat (3) @(negedge clk);
        check_idle("rst", 0);
        rst = 1'b0;
        @(negedge clk);

        // A: single RGB888 frame, sync counts and fetch-latency alignment
        push_frame(1, 3'd0, 1'b0, -1);
        h0 = n_hd; v0 = n_vd; d0 = n_den; k0 = n_done;
        start = 1'b1; mode = 2'd1; cont = 1'b0; vflip = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_addr(200, "A_valid", 1'b1, 0, 0);
        lat = 0;
        for (int i = 0; i < 10 && !o_DEN; i++) begin @(negedge clk); lat++; end
        chk("A_den_latency", lat, L);
        wait_done(FRAME + 50, "A_done", n);
        repeat (L + 1) @(negedge clk);
        chk("A_hd_low", n_hd - h0, V_T);
        chk("A_vd_low", n_vd - v0, H_T);
        chk("A_den_cycles", n_den - d0, VH * HW);
        chk("A_done_pulses", n_done - k0, 1);
        chk("A_queue_empty", exp_q.size(), 0);
        check_idle("A_end", 1);

        // B: vertical flip latched at start; mid-frame toggle ignored
        push_frame(1, 3'd0, 1'b1, -1);
        start = 1'b1; vflip = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_addr(200, "B_valid", 1'b1, 0, 0);
        chk("B_first_y", o_addr_y, VH - 1);
        chk("B_first_x", o_addr_x, 0);
        vflip = 1'b0;
        wait_done(FRAME + 50, "B_done", n);
        repeat (L + 1) @(negedge clk);
        chk("B_queue_empty", exp_q.size(), 0);
        chk("B_cnt", o_frame_cnt, 2);

        // C: three chained frames: colour bars, gray, solid 101
        push_frame(3, 3'd0, 1'b0, -1);
        push_frame(0, 3'd0, 1'b0, -1);
        push_frame(2, 3'b101, 1'b0, -1);
        start = 1'b1; mode = 2'd3; cont = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'd0;
        wait_done(FRAME + 10, "C_done1", n);
        @(negedge clk);
        chk("C_busy1", o_busy, 1);
        mode = 2'd2; mask = 3'b101;
        wait_done(FRAME + 10, "C_done2", n);
        chk("C_period1", n + 1, FRAME);
        @(negedge clk);
        chk("C_busy2", o_busy, 1);
        cont = 1'b0;
        wait_done(FRAME + 10, "C_done3", n);
        chk("C_period2", n + 1, FRAME);
        @(negedge clk);
        chk("C_busy_end", o_busy, 0);
        repeat (L) @(negedge clk);
        chk("C_queue_empty", exp_q.size(), 0);
        chk("C_cnt", o_frame_cnt, 5);

        // D: restart mid-frame at pixel (3,2)
        push_frame(1, 3'd0, 1'b0, 2 * HW + 4);
        push_frame(1, 3'd0, 1'b0, -1);
        mode = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_addr(200, "D_addr", 1'b0, 3, 2);
        start = 1'b1;
        c0 = o_frame_cnt;
        k0 = n_done;
        @(negedge clk);
        start = 1'b0;
        chk("D_cnt_same", o_frame_cnt, c0);
        chk("D_busy", o_busy, 1);
        chk("D_valid_x0", o_addr_valid, 0);
        repeat (L) @(negedge clk);
        chk("D_sync_origin", {o_HD, o_VD}, 2'b00);
        chk("D_no_done", n_done - k0, 0);
        wait_done(FRAME + 50, "D_done", n);
        repeat (L + 1) @(negedge clk);
        chk("D_queue_empty", exp_q.size(), 0);
        chk("D_cnt", o_frame_cnt, 32'(c0) + 1);

        // E: asynchronous reset mid-frame, checked before any clock edge
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_addr(200, "E_valid", 1'b1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle("E_rst", 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("E_queue_empty", exp_q.size(), 0);
        chk("E_idle_busy", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
